// File: rtl/apb_regfile_pkg.sv
// Shared types and constants for the parametrised APB register file.
// Optional byte-lane write strobes are enabled with the APB_PSTRB_EN macro.
package apb_regfile_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam int DATA_W_8        = 8;
   localparam int DATA_W_16       = 16;
   localparam int DATA_W_32       = 32;
   localparam int MAX_WAIT_STATES = 15;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

   localparam int WAIT_CTR_W = clog2(MAX_WAIT_STATES + 1);

endpackage

// File: rtl/apb_wait_ctr.sv
// Wait-state counter: counts ACCESS cycles and raises done once WAIT_STATES
// extra cycles have elapsed. Held at zero while clear is asserted.
module apb_wait_ctr
   import apb_regfile_pkg::*;
#(
   parameter int WAIT_STATES = 0
) (
   input  logic pclk,
   input  logic preset,
   input  logic clear,
   output logic done
);

   logic [WAIT_CTR_W-1:0] count;

   assign done = (count == WAIT_CTR_W'(WAIT_STATES));

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge pclk) begin
      if (preset || clear) begin
         count <= '0;
      end else if (!done) begin
         count <= count + WAIT_CTR_W'(1);
      end
   end

endmodule

// File: rtl/apb_regfile_gen.sv
// Parametrised APB slave register file with wait states, PSLVERR and read-only masking.
// Define APB_PSTRB_EN to add the pstrb byte-lane write strobe input.
module apb_regfile_gen
   import apb_regfile_pkg::*;
#(
   parameter int                  DATA_W      = 8,
   parameter int                  NUM_REGS    = 8,
   parameter int                  ADDR_W      = 8,
   parameter int                  WAIT_STATES = 0,
   parameter logic [DATA_W-1:0]   RESET_VAL   = '0,
   parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
   input  logic                       pclk,
   input  logic                       preset,
   input  logic                       psel,
   input  logic                       penable,
   input  logic                       pwrite,
   input  logic [ADDR_W-1:0]          paddr,
   input  logic [DATA_W-1:0]          pwdata,
`ifdef APB_PSTRB_EN
   input  logic [DATA_W/8-1:0]        pstrb,
`endif
   output logic [DATA_W-1:0]          prdata,
   output logic                       pready,
   output logic                       pslverr,
   output logic [NUM_REGS*DATA_W-1:0] reg_out,
   output logic [NUM_REGS-1:0]        reg_wr_stb
);

   localparam int LANES  = DATA_W / 8;
   localparam int LSB    = clog2(LANES);
   localparam int RIDX_W = (NUM_REGS > 1) ? clog2(NUM_REGS) : 1;
   localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << LSB) - 1);

   if (DATA_W != DATA_W_8 && DATA_W != DATA_W_16 && DATA_W != DATA_W_32) begin : g_bad_data_w
      $error("apb_regfile_gen: DATA_W must be 8, 16 or 32");
   end
   if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait
      $error("apb_regfile_gen: WAIT_STATES out of range");
   end

   state_t              state, state_next;
   logic                done, valid, ro_hit, err, complete, do_write;
   logic [ADDR_W-1:0]   idx;
   logic [RIDX_W-1:0]   ridx;
   logic [LANES-1:0]    lane_en;
   logic [DATA_W-1:0]   regs [NUM_REGS];

   assign idx    = paddr >> LSB;
   assign ridx   = idx[RIDX_W-1:0];
   assign valid  = ((paddr & OFFSET_MASK) == '0) && (int'(idx) < NUM_REGS);
   assign ro_hit = valid && RO_MASK[ridx];
   assign err    = !valid || (pwrite && ro_hit);

   assign complete = (state == ACCESS) && psel && done;
   assign pready   = complete;
   assign pslverr  = complete && err;
   assign prdata   = (complete && !pwrite && !err) ? regs[ridx] : '0;
   assign do_write = complete && pwrite && !err;

`ifdef APB_PSTRB_EN
   assign lane_en = pstrb;
`else
   assign lane_en = '1;
`endif

   apb_wait_ctr #(
      .WAIT_STATES (WAIT_STATES)
   ) u_wait_ctr (
      .pclk   (pclk),
      .preset (preset),
      .clear  (state != ACCESS),
      .done   (done)
   );

   always_ff @(posedge pclk) begin
      if (preset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: next state defaults to the current state first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (psel && !penable) state_next = ACCESS;
         ACCESS:  if (!psel || done)    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: the register array is a bank of flops downstream logic reads directly,
   // so each entry is reset to a known value rather than left undefined like a RAM.
   always_ff @(posedge pclk) begin
      if (preset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= RESET_VAL;
         end
         reg_wr_stb <= '0;
      end else begin
         reg_wr_stb <= '0;
         if (do_write && (|lane_en)) begin
            for (int b = 0; b < LANES; b++) begin
               if (lane_en[b]) begin
                  regs[ridx][b*8 +: 8] <= pwdata[b*8 +: 8];
               end
            end
            reg_wr_stb[ridx] <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
      assign reg_out[i*DATA_W +: DATA_W] = regs[i];
   end

endmodule

// File: tb/tb_apb_regfile_gen.sv
// Scoreboard bench for apb_regfile_gen: an 8-bit zero-wait instance (a) and a
// 32-bit three-wait-state instance (b) share one APB bus with separate selects.
module tb_apb_regfile_gen;

   typedef struct {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic         pclk;
   logic         preset;
   logic         psel_a, psel_b, penable, pwrite;
   logic [7:0]   paddr;
   logic [31:0]  pwdata;
   logic [3:0]   pstrb;

   logic [7:0]   prdata_a;
   logic         pready_a, slverr_a;
   logic [63:0]  reg_out_a;
   logic [7:0]   stb_a;

   logic [31:0]  prdata_b;
   logic         pready_b, slverr_b;
   logic [127:0] reg_out_b;
   logic [3:0]   stb_b;

   exp_t q_a[$];
   exp_t q_b[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   lat;

   apb_regfile_gen #(
      .DATA_W(8), .NUM_REGS(8), .ADDR_W(8), .WAIT_STATES(0),
      .RESET_VAL(8'h11), .RO_MASK(8'h80)
   ) u_a (
      .pclk(pclk), .preset(preset), .psel(psel_a), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata[7:0]),
`ifdef APB_PSTRB_EN
      .pstrb(pstrb[0:0]),
`endif
      .prdata(prdata_a), .pready(pready_a), .pslverr(slverr_a),
      .reg_out(reg_out_a), .reg_wr_stb(stb_a)
   );

   apb_regfile_gen #(
      .DATA_W(32), .NUM_REGS(4), .ADDR_W(8), .WAIT_STATES(3),
      .RESET_VAL(32'h0), .RO_MASK(4'b0010)
   ) u_b (
      .pclk(pclk), .preset(preset), .psel(psel_b), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
      .pstrb(pstrb),
`endif
      .prdata(prdata_b), .pready(pready_b), .pslverr(slverr_b),
      .reg_out(reg_out_b), .reg_wr_stb(stb_b)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitors: pop one expectation per pready cycle; outputs must idle at zero otherwise.
   always @(negedge pclk) begin
      exp_t e;
      if (!preset) begin
         if (pready_a === 1'b1) begin
            if (q_a.size() == 0) begin
               check("a_spurious_pready", 64'(pready_a), 64'd0);
            end else begin
               e = q_a.pop_front();
               check("a_prdata", 64'(prdata_a), 64'(e.rd));
               check("a_pslverr", 64'(slverr_a), 64'(e.err));
            end
         end else begin
            check("a_idle_prdata", 64'(prdata_a), 64'd0);
         end
      end
   end

   always @(negedge pclk) begin
      exp_t e;
      if (!preset) begin
         if (pready_b === 1'b1) begin
            if (q_b.size() == 0) begin
               check("b_spurious_pready", 64'(pready_b), 64'd0);
            end else begin
               e = q_b.pop_front();
               check("b_prdata", 64'(prdata_b), 64'(e.rd));
               check("b_pslverr", 64'(slverr_b), 64'(e.err));
            end
         end else begin
            check("b_idle_prdata", 64'(prdata_b), 64'd0);
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that follows completion.
   task automatic xfer(input int which, input bit wr, input logic [7:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_rd,
                       input bit exp_err, output int n);
      exp_t e;
      logic rdy;
      e.rd  = exp_rd;
      e.err = exp_err;
      if (which == 0) q_a.push_back(e);
      else            q_b.push_back(e);
      psel_a  = (which == 0);
      psel_b  = (which == 1);
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = data;
      @(posedge pclk); #1;
      penable = 1'b1;
      n = 0;
      do begin
         @(negedge pclk);
         n++;
         rdy = (which == 0) ? pready_a : pready_b;
      end while (!rdy && n < 40);
      check("xfer_pready", 64'(rdy), 64'd1);
      @(posedge pclk); #1;
      psel_a  = 1'b0;
      psel_b  = 1'b0;
      penable = 1'b0;
   endtask

   task automatic do_reset();
      preset = 1'b1;
      repeat (2) @(posedge pclk);
      #1;
      preset = 1'b0;
   endtask

   initial begin
      psel_a = 0; psel_b = 0; penable = 0; pwrite = 0;
      paddr = '0; pwdata = '0; pstrb = 4'hF;
      do_reset();

      check("rst_reg_out_a", reg_out_a, 64'h1111111111111111);
      check("rst_reg_out_b", reg_out_b[63:0], 64'd0);
      check("rst_pready_a", 64'(pready_a), 64'd0);
      check("rst_prdata_b", 64'(prdata_b), 64'd0);
      check("rst_stb", 64'({stb_a, stb_b}), 64'd0);

      // Zero-wait write then back-to-back read of the same register.
      xfer(0, 1'b1, 8'h05, 32'h3C, 32'h0, 1'b0, lat);
      check("a_wr_latency", 64'(lat), 64'd1);
      check("a_wr_stb", 64'(stb_a), 64'h20);
      check("a_wr_reg_out", reg_out_a, 64'h11113C1111111111);
      xfer(0, 1'b0, 8'h05, 32'h0, 32'h3C, 1'b0, lat);
      check("a_stb_one_cycle", 64'(stb_a), 64'd0);

      // Out-of-range address.
      xfer(0, 1'b1, 8'h0A, 32'hFF, 32'h0, 1'b1, lat);
      check("a_bad_wr_stb", 64'(stb_a), 64'd0);
      check("a_bad_wr_reg_out", reg_out_a, 64'h11113C1111111111);
      xfer(0, 1'b0, 8'h0A, 32'h0, 32'h0, 1'b1, lat);

      // Register 7 is read-only; reads still succeed.
      xfer(0, 1'b1, 8'h07, 32'h77, 32'h0, 1'b1, lat);
      check("a_ro_stb", 64'(stb_a), 64'd0);
      xfer(0, 1'b0, 8'h07, 32'h0, 32'h11, 1'b0, lat);
      xfer(0, 1'b0, 8'h00, 32'h0, 32'h11, 1'b0, lat);

      // Reset after a write restores RESET_VAL everywhere.
      xfer(0, 1'b1, 8'h03, 32'hA5, 32'h0, 1'b0, lat);
      check("a_pre_rst_reg3", 64'(reg_out_a[31:24]), 64'hA5);
      do_reset();
      check("a_post_rst_reg_out", reg_out_a, 64'h1111111111111111);
      check("a_post_rst_pready", 64'(pready_a), 64'd0);

      // 32-bit instance with three wait states.
      xfer(1, 1'b0, 8'h01, 32'h0, 32'h0, 1'b1, lat);
      check("b_wait_latency", 64'(lat), 64'd4);
      xfer(1, 1'b1, 8'h04, 32'h12345678, 32'h0, 1'b1, lat);
      check("b_ro_stb", 64'(stb_b), 64'd0);
      check("b_ro_reg1", 64'(reg_out_b[63:32]), 64'd0);
      xfer(1, 1'b0, 8'h04, 32'h0, 32'h0, 1'b0, lat);
      xfer(1, 1'b1, 8'h02, 32'hFFFFFFFF, 32'h0, 1'b1, lat);
      xfer(1, 1'b1, 8'h10, 32'hFFFFFFFF, 32'h0, 1'b1, lat);
      check("b_bad_reg_out", reg_out_b, 128'd0);
      xfer(1, 1'b1, 8'h08, 32'hCAFEF00D, 32'h0, 1'b0, lat);
      check("b_wr_stb", 64'(stb_b), 64'h4);
      check("b_wr_reg2", 64'(reg_out_b[95:64]), 64'hCAFEF00D);
      xfer(1, 1'b0, 8'h08, 32'h0, 32'hCAFEF00D, 1'b0, lat);
      check("b_rd_latency", 64'(lat), 64'd4);

      // Drop psel during a wait state: the write must not land.
      psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'hDEADBEEF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      psel_b = 1'b0; penable = 1'b0;
      repeat (2) @(posedge pclk);
      #1;
      check("b_abort_stb", 64'(stb_b), 64'd0);
      check("b_abort_reg3", 64'(reg_out_b[127:96]), 64'd0);
      xfer(1, 1'b0, 8'h0C, 32'h0, 32'h0, 1'b0, lat);

`ifdef APB_PSTRB_EN
      pstrb = 4'b0101;
      xfer(1, 1'b1, 8'h00, 32'hAABBCCDD, 32'h0, 1'b0, lat);
      check("b_pstrb_stb", 64'(stb_b), 64'h1);
      check("b_pstrb_reg0", 64'(reg_out_b[31:0]), 64'h00BB00DD);
      pstrb = 4'b0000;
      xfer(1, 1'b1, 8'h00, 32'hFFFFFFFF, 32'h0, 1'b0, lat);
      check("b_pstrb0_stb", 64'(stb_b), 64'd0);
      check("b_pstrb0_reg0", 64'(reg_out_b[31:0]), 64'h00BB00DD);
      pstrb = 4'hF;
      xfer(1, 1'b0, 8'h00, 32'h0, 32'h00BB00DD, 1'b0, lat);
`endif

      repeat (2) @(posedge pclk);
      check("a_queue_drained", 64'(q_a.size()), 64'd0);
      check("b_queue_drained", 64'(q_b.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
